// File: rtl/dtc_vote_if.sv
// dtc_vote_if: sample-in / vote-out handshake bundle of the vote collector.
interface dtc_vote_if #(
  parameter int CLASS_W = 3,
  parameter int CNT_W   = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [CLASS_W-1:0] in_class;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [CLASS_W-1:0] out_class;
  logic [CNT_W-1:0]   out_count;
  logic               busy;
  modport master (
    output in_valid, in_class, flush, out_ready,
    input  in_ready, out_valid, out_class, out_count, busy
  );
  modport slave (
    input  in_valid, in_class, flush, out_ready,
    output in_ready, out_valid, out_class, out_count, busy
  );
endinterface

// File: rtl/dtc_vote_collector.sv
// dtc_vote_collector: windowed histogram of class predictions reduced to a majority vote.
module dtc_vote_collector #(
  parameter int CLASS_W = 3,
  parameter int WINDOW  = 8,
  parameter int CNT_W   = 4
) (
  input logic       clk,
  input logic       rst,
  dtc_vote_if.slave bus
);
  localparam int NBINS = 2**CLASS_W;
  typedef enum logic [1:0] {ACCUM, REDUCE, HOLD} state_t;
  state_t             r_state;
  logic [CNT_W-1:0]   r_bins [NBINS];
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_best_count;
  logic [CLASS_W-1:0] r_best_class;
  logic [CLASS_W:0]   r_idx;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;
  logic               w_acc;
  logic               w_close;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [CNT_W-1:0]   w_bin;
  assign w_acc      = bus.in_valid & r_in_ready;
  assign w_cnt_next = r_cnt + CNT_W'(w_acc);
  assign w_close    = (w_acc && w_cnt_next == CNT_W'(WINDOW)) || (bus.flush && w_cnt_next != '0);
  assign w_bin      = r_bins[r_idx[CLASS_W-1:0]];
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_class = r_best_class;
  assign bus.out_count = r_best_count;
  assign bus.busy      = r_busy;
  // r_idx carries one extra bit: the scan spends a ninth cycle at idx==NBINS to enter HOLD
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state      <= ACCUM;
      for (int i = 0; i < NBINS; i++) r_bins[i] <= '0;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_best_class <= '0;
      r_best_count <= '0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
    end else
      case (r_state)
        ACCUM: begin
          if (w_acc) begin
            r_bins[bus.in_class] <= r_bins[bus.in_class] + CNT_W'(1);
            r_cnt                <= w_cnt_next;
          end
          if (w_close) begin
            r_state      <= REDUCE;
            r_idx        <= '0;
            r_best_class <= '0;
            r_best_count <= '0;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b1;
          end
        end
        REDUCE:
          if (r_idx[CLASS_W]) begin
            r_state     <= HOLD;
            r_out_valid <= 1'b1;
          end else begin
            if (w_bin > r_best_count) begin
              r_best_count <= w_bin;
              r_best_class <= r_idx[CLASS_W-1:0];
            end
            r_idx <= r_idx + (CLASS_W+1)'(1);
          end
        HOLD:
          if (bus.out_ready) begin
            for (int i = 0; i < NBINS; i++) r_bins[i] <= '0;
            r_cnt       <= '0;
            r_state     <= ACCUM;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        default: r_state <= ACCUM;
      endcase
endmodule

// File: doc/dtc_vote_collector.md
Name: dtc_vote_collector

Overview:
- Receiving end of the 3-bit class output produced by the combinational decision-tree classifiers.
- Accepts a stream of class predictions over a valid/ready handshake and accumulates a per-class histogram over a window of WINDOW samples, or fewer if flushed early.
- Reduces the histogram to a majority-vote class and presents it with its vote count on a valid/ready output.
- Sits between a classifier bank (or a time-multiplexed classifier) and downstream decision logic.

Parameters:
- CLASS_W, 3: width of class code; the histogram has 2**CLASS_W bins (8).
- WINDOW, 8: samples per vote window; legal range is 1..(2**CNT_W)-1.
- CNT_W, 4: width of each bin counter, the sample counter and out_count.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: in_class is valid.
- in_ready, output, 1: collector can accept a sample this cycle.
- in_class, input, CLASS_W: class prediction (classifier outp).
- flush, input, 1: close the current window early. Sampled only in ACCUM.
- out_valid, output, 1: vote result is valid.
- out_ready, input, 1: downstream accepts the result.
- out_class, output, CLASS_W: winning class.
- out_count, output, CNT_W: number of votes for out_class.
- busy, output, 1: high in REDUCE or HOLD.

Behaviour:
- Reset (async, rst=1):
  - State goes to ACCUM.
  - All bin counters, the sample counter, the scan index, best_class and best_count clear to 0.
  - Outputs: in_ready=1, out_valid=0, out_class=0, out_count=0, busy=0.
  - Reset asserted mid-window or mid-REDUCE discards everything. No partial result is emitted.
- States: ACCUM, REDUCE, HOLD.
- ACCUM:
  - in_ready=1.
  - An accept occurs when in_valid and in_ready are both high. On an accept, bin[in_class] and the sample counter increment.
  - The window closes in either of two cases:
    - an accept brings the sample count to WINDOW;
    - flush=1 while the sample count, including any accept in the same cycle, is 1 or more.
  - When the window closes, the next state is REDUCE, with scan index=0, best_class=0, best_count=0.
  - If flush and an accept occur in the same cycle, the sample is counted, then the window closes.
  - flush with zero samples and no accept is ignored and the state stays in ACCUM.
- REDUCE:
  - in_ready=0. One bin is examined per cycle, idx 0..7, for 8 cycles total.
  - If bin[idx] > best_count, then best_count<=bin[idx] and best_class<=idx.
  - Strict greater-than means ties resolve to the lowest class index.
  - After idx=7 the next state is HOLD.
- HOLD:
  - in_ready=0, out_valid=1.
  - out_class and out_count equal best_class and best_count, and stay stable until out_ready.
  - On out_valid and out_ready both high: all bins and the sample counter clear and the next state is ACCUM. in_ready rises the following cycle.
  - out_ready high outside HOLD has no effect.
- Latency: the final accept, or the closing flush, at edge t gives out_valid=1 after edge t+9, i.e. 8 REDUCE cycles plus the HOLD entry.
- Width rules:
  - Bins cannot overflow because WINDOW ≤ 2**CNT_W-1.
  - out_count ≤ WINDOW, and out_count ≥ 1 for any emitted result.
- busy = (state==REDUCE) or (state==HOLD).

Test Plan:
1. Reset then 8 accepts of class 5, WINDOW=8 -> out_valid exactly 9 cycles after the 8th accept; out_class=5, out_count=8. in_ready=0 from the cycle after the 8th accept until the handshake.
2. Classes 2,2,6,6,6,1,2,6 -> out_class=6, out_count=4.
3. Tie case, classes 3,3,3,3,7,7,7,7 -> out_class=3, out_count=4 (lowest index wins).
4. Early close: 3 accepts of class 4, then flush with no accept -> out_class=4, out_count=3. Also assert flush at 0 samples -> no transition, in_ready stays 1.
5. Output stall: hold out_ready=0 for 20 cycles in HOLD -> out_valid, out_class and out_count stay stable and in_valid samples are not accepted. Then raise out_ready for 1 cycle -> next window starts from empty bins (single class-0 sample plus flush yields out_count=1).
6. Assert rst for 1 cycle during REDUCE (cycle 4) -> out_valid never rises for that window; in_ready=1 immediately after reset; following window result is unaffected by pre-reset samples.
